// File: rtl/irq_controller.sv
// irq_controller: edge-triggered interrupt collector in front of the core.
// Rising edges on irq_src latch into pending. The lowest-numbered source that
// is both pending and enabled is offered to the core on interrupt/irq_id and
// then tracked as in service until the core signals end-of-interrupt.
//
// Build option: define IRQ_SYNC_EN to pass each irq_src bit through a two-flop
// synchronizer before edge detection. This allows asynchronous sources and
// adds two cycles of latency. Without it, irq_src must be synchronous to clk.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no request outstanding; waiting for an enabled pending source
// S_REQ   | interrupt raised for irq_id; waiting for irq_ack
// S_ACTIVE| handler running for irq_id; waiting for irq_eoi
module irq_controller #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               irq_ack,
  input  logic               irq_eoi,
  output logic               interrupt,
  output logic [ID_W-1:0]    irq_id,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask
);

  // The encoding puts REQ and ACTIVE on separate bits, so interrupt and
  // in_service come straight from a state flop.
  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_REQ    = 2'b01,
    S_ACTIVE = 2'b10
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [NUM_IRQ-1:0] src_lvl;
  logic [NUM_IRQ-1:0] src_prev;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] enabled;
  logic [NUM_IRQ-1:0] clr_vec;
  logic               any_enabled;
  logic [ID_W-1:0]    win_id;
  logic               ack_take;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync_q1;
  logic [NUM_IRQ-1:0] sync_q2;

  // Two-flop synchronizer for each request line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_src;
      sync_q2 <= sync_q1;
    end
  end

  assign src_lvl = sync_q2;
`else
  assign src_lvl = irq_src;
`endif

  // Previous level of each source, used for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_prev <= '0;
    end else begin
      src_prev <= src_lvl;
    end
  end

  assign rise        = src_lvl & ~src_prev;
  assign enabled     = pending & mask;
  assign any_enabled = |enabled;
  assign ack_take    = (state == S_REQ) && irq_ack;

  // Priority select: scan from the top down so the lowest enabled index wins.
  always_comb begin
    win_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (enabled[i]) begin
        win_id = ID_W'(i);
      end
    end
  end

  // One-hot clear of the acknowledged source.
  always_comb begin
    clr_vec = '0;
    if (ack_take) begin
      clr_vec[irq_id] = 1'b1;
    end
  end

  // Pending register. A new edge wins over a same-cycle acknowledge clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_vec) | rise;
    end
  end

  // Software-written enable mask.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask <= '0;
    end else if (mask_we) begin
      mask <= mask_wdata;
    end
  end

  // Latch the winner when leaving IDLE; held through REQ and ACTIVE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_id <= '0;
    end else if ((state == S_IDLE) && any_enabled) begin
      irq_id <= win_id;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic. Mask changes in REQ do not retract the request.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (any_enabled) state_nxt = S_REQ;
      S_REQ:    if (irq_ack)     state_nxt = S_ACTIVE;
      S_ACTIVE: if (irq_eoi)     state_nxt = S_IDLE;
      default:                   state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs, taken directly from the state flops.
  always_comb begin
    interrupt  = state[0];
    in_service = state[1];
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed testbench for irq_controller (default build, no synchronizer).
// Inputs change 1 ns after a rising edge and outputs are sampled at the same
// point, so "after edge k" is observed right after each tick.
module tb_irq_controller;

  logic       clk;
  logic       rst;
  logic [7:0] irq_src;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       irq_ack;
  logic       irq_eoi;
  logic       interrupt;
  logic [2:0] irq_id;
  logic       in_service;
  logic [7:0] pending;
  logic [7:0] mask;

  int passed = 0;
  int total  = 0;

  irq_controller #(.NUM_IRQ(8), .ID_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_src    (irq_src),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .irq_ack    (irq_ack),
    .irq_eoi    (irq_eoi),
    .interrupt  (interrupt),
    .irq_id     (irq_id),
    .in_service (in_service),
    .pending    (pending),
    .mask       (mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    tick();
    mask_we    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; irq_src = '0; mask_we = 1'b0; mask_wdata = '0;
    irq_ack = 1'b0; irq_eoi = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    total++; if (interrupt !== 1'b0) $display("FAIL rst_interrupt: got %b want 0", interrupt); else passed++;
    total++; if (in_service !== 1'b0) $display("FAIL rst_in_service: got %b want 0", in_service); else passed++;
    total++; if (irq_id !== 3'd0) $display("FAIL rst_irq_id: got %0d want 0", irq_id); else passed++;
    total++; if (pending !== 8'h00) $display("FAIL rst_pending: got %h want 00", pending); else passed++;
    total++; if (mask !== 8'h00) $display("FAIL rst_mask: got %h want 00", mask); else passed++;
  endtask

  task automatic test_single();
    write_mask(8'h08);
    total++; if (mask !== 8'h08) $display("FAIL single_mask: got %h want 08", mask); else passed++;
    irq_src = 8'h08;
    tick();
    total++; if (pending !== 8'h08) $display("FAIL single_pend: got %h want 08", pending); else passed++;
    total++; if (interrupt !== 1'b0) $display("FAIL single_int_early: got %b want 0", interrupt); else passed++;
    irq_src = 8'h00;
    tick();
    total++; if (interrupt !== 1'b1) $display("FAIL single_int: got %b want 1", interrupt); else passed++;
    total++; if (irq_id !== 3'd3) $display("FAIL single_id: got %0d want 3", irq_id); else passed++;
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    total++; if (interrupt !== 1'b0) $display("FAIL single_ack_int: got %b want 0", interrupt); else passed++;
    total++; if (in_service !== 1'b1) $display("FAIL single_ack_insvc: got %b want 1", in_service); else passed++;
    total++; if (pending !== 8'h00) $display("FAIL single_ack_pend: got %h want 00", pending); else passed++;
    total++; if (irq_id !== 3'd3) $display("FAIL single_ack_id: got %0d want 3", irq_id); else passed++;
    tick();
    total++; if (in_service !== 1'b1) $display("FAIL single_hold_insvc: got %b want 1", in_service); else passed++;
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
    total++; if (in_service !== 1'b0) $display("FAIL single_eoi_insvc: got %b want 0", in_service); else passed++;
    tick();
    total++; if (interrupt !== 1'b0) $display("FAIL single_idle_int: got %b want 0", interrupt); else passed++;
  endtask

  task automatic test_priority();
    write_mask(8'hFF);
    irq_src = 8'h24;
    tick();
    total++; if (pending !== 8'h24) $display("FAIL prio_pend: got %h want 24", pending); else passed++;
    irq_src = 8'h00;
    tick();
    total++; if (interrupt !== 1'b1) $display("FAIL prio_int1: got %b want 1", interrupt); else passed++;
    total++; if (irq_id !== 3'd2) $display("FAIL prio_id1: got %0d want 2", irq_id); else passed++;
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    total++; if (pending !== 8'h20) $display("FAIL prio_pend_after_ack: got %h want 20", pending); else passed++;
    total++; if (interrupt !== 1'b0) $display("FAIL prio_no_nesting: got %b want 0", interrupt); else passed++;
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
    total++; if (interrupt !== 1'b0) $display("FAIL prio_idle_gap: got %b want 0", interrupt); else passed++;
    tick();
    total++; if (interrupt !== 1'b1) $display("FAIL prio_int2: got %b want 1", interrupt); else passed++;
    total++; if (irq_id !== 3'd5) $display("FAIL prio_id2: got %0d want 5", irq_id); else passed++;
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
    total++; if (pending !== 8'h00) $display("FAIL prio_final_pend: got %h want 00", pending); else passed++;
  endtask

  task automatic test_masked_pending();
    write_mask(8'h00);
    irq_src = 8'h02;
    tick();
    irq_src = 8'h00;
    tick();
    total++; if (pending !== 8'h02) $display("FAIL masked_pend: got %h want 02", pending); else passed++;
    total++; if (interrupt !== 1'b0) $display("FAIL masked_int: got %b want 0", interrupt); else passed++;
    tick();
    total++; if (interrupt !== 1'b0) $display("FAIL masked_int_hold: got %b want 0", interrupt); else passed++;
    write_mask(8'h02);
    total++; if (interrupt !== 1'b0) $display("FAIL masked_int_at_write: got %b want 0", interrupt); else passed++;
    tick();
    total++; if (interrupt !== 1'b1) $display("FAIL masked_int_enabled: got %b want 1", interrupt); else passed++;
    total++; if (irq_id !== 3'd1) $display("FAIL masked_id: got %0d want 1", irq_id); else passed++;
    write_mask(8'h00);
    total++; if (interrupt !== 1'b1) $display("FAIL masked_no_retract: got %b want 1", interrupt); else passed++;
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
    total++; if (in_service !== 1'b0) $display("FAIL masked_done: got %b want 0", in_service); else passed++;
  endtask

  task automatic test_collision();
    write_mask(8'h10);
    irq_src = 8'h10;
    tick();
    irq_src = 8'h00;
    tick();
    total++; if (irq_id !== 3'd4) $display("FAIL coll_id: got %0d want 4", irq_id); else passed++;
    irq_src = 8'h10;
    irq_ack = 1'b1;
    tick();
    irq_src = 8'h00;
    irq_ack = 1'b0;
    total++; if (pending !== 8'h10) $display("FAIL coll_pend: got %h want 10", pending); else passed++;
    total++; if (in_service !== 1'b1) $display("FAIL coll_insvc: got %b want 1", in_service); else passed++;
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
    total++; if (interrupt !== 1'b0) $display("FAIL coll_gap: got %b want 0", interrupt); else passed++;
    tick();
    total++; if (interrupt !== 1'b1) $display("FAIL coll_rereq: got %b want 1", interrupt); else passed++;
    total++; if (irq_id !== 3'd4) $display("FAIL coll_reid: got %0d want 4", irq_id); else passed++;
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
    total++; if (pending !== 8'h00) $display("FAIL coll_final_pend: got %h want 00", pending); else passed++;
  endtask

  task automatic test_spurious();
    write_mask(8'h00);
    irq_src = 8'h40;
    tick();
    irq_src = 8'h00;
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    total++; if (in_service !== 1'b0) $display("FAIL spur_ack_insvc: got %b want 0", in_service); else passed++;
    total++; if (interrupt !== 1'b0) $display("FAIL spur_ack_int: got %b want 0", interrupt); else passed++;
    total++; if (pending !== 8'h40) $display("FAIL spur_ack_pend: got %h want 40", pending); else passed++;
    write_mask(8'h40);
    tick();
    total++; if (interrupt !== 1'b1) $display("FAIL spur_req: got %b want 1", interrupt); else passed++;
    total++; if (irq_id !== 3'd6) $display("FAIL spur_id: got %0d want 6", irq_id); else passed++;
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
    total++; if (interrupt !== 1'b1) $display("FAIL spur_eoi_int: got %b want 1", interrupt); else passed++;
    total++; if (in_service !== 1'b0) $display("FAIL spur_eoi_insvc: got %b want 0", in_service); else passed++;
    total++; if (pending !== 8'h40) $display("FAIL spur_eoi_pend: got %h want 40", pending); else passed++;
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    total++; if (in_service !== 1'b1) $display("FAIL spur_ack_ok: got %b want 1", in_service); else passed++;
    total++; if (pending !== 8'h00) $display("FAIL spur_clr: got %h want 00", pending); else passed++;
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
  endtask

  task automatic test_reset_mid_req();
    write_mask(8'h01);
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    tick();
    total++; if (interrupt !== 1'b1) $display("FAIL mid_setup_int: got %b want 1", interrupt); else passed++;
    #2;
    rst = 1'b0;
    #1;
    total++; if (interrupt !== 1'b0) $display("FAIL mid_rst_int: got %b want 0", interrupt); else passed++;
    total++; if (irq_id !== 3'd0) $display("FAIL mid_rst_id: got %0d want 0", irq_id); else passed++;
    total++; if (in_service !== 1'b0) $display("FAIL mid_rst_insvc: got %b want 0", in_service); else passed++;
    total++; if (pending !== 8'h00) $display("FAIL mid_rst_pend: got %h want 00", pending); else passed++;
    total++; if (mask !== 8'h00) $display("FAIL mid_rst_mask: got %h want 00", mask); else passed++;
    tick();
    rst = 1'b1;
    tick(); tick();
    total++; if (interrupt !== 1'b0) $display("FAIL mid_post_int: got %b want 0", interrupt); else passed++;
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    total++; if (in_service !== 1'b0) $display("FAIL mid_post_idle: got %b want 0", in_service); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_masked_pending();
    test_collision();
    test_spurious();
    test_reset_mid_req();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
